// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the execute-stage multiply/divide unit.
//   - hilo_op_e      : 4-bit HI/LO operation code produced by the decoder
//   - DEF_*_CYCLES   : default busy latencies for multiply and divide
//   - CNT_W          : width of the latency countdown
//   - is_md_op()     : ops that occupy the unit for several cycles
//   - is_div_op()    : ops that use the divide latency
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu (9-12).
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam int CNT_W           = 4;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Codes 13-15 are reserved and decode as "none" everywhere.
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } hilo_op_e;

  function automatic logic is_md_op(hilo_op_e op);
    logic md;
    md = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: md = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: md = 1'b1;
`endif
      default: md = 1'b0;
    endcase
    return md;
  endfunction

  function automatic logic is_div_op(hilo_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if
// Connection between the E stage / hazard unit (master) and the
// multiply/divide unit (slave).
//   HILOOp  : operation code of the instruction in E      (master -> slave)
//   A, B    : forwarded rs / rt operand values             (master -> slave)
//   Start   : md op accepted this cycle (combinational)    (slave -> master)
//   Busy    : operation in flight (registered)             (slave -> master)
//   HILOOut : mfhi/mflo read value, 0 for other ops        (slave -> master)
// -----------------------------------------------------------------------------
interface mdu_if;
  logic [3:0]  HILOOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HILOOut;

  modport master (
    output HILOOp, A, B,
    input  Start, Busy, HILOOut
  );

  modport slave (
    input  HILOOp, A, B,
    output Start, Busy, HILOOut
  );
endinterface

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith
// Purely combinational datapath of the multiply/divide unit. Produces the
// 64-bit {hi,lo} result an op will commit, plus a divide-by-zero flag.
//   op_i          : decoded HI/LO operation
//   a_i, b_i      : operands (rs, rt)
//   hi_i, lo_i    : committed hi/lo (accumulation base for the madd family)
//   result_o      : {hi, lo} result; don't-care when div_by_zero_o is set
//   div_by_zero_o : div/divu with b_i == 0
// Optional feature: MDU_MADD_EN adds the madd/maddu/msub/msubu accumulator.
// -----------------------------------------------------------------------------
module mdu_arith
  import mdu_pkg::*;
(
  input  hilo_op_e    op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               sdiv_ovf;
  logic        [31:0] divisor_s;
  logic        [31:0] divisor_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  assign b_zero   = (b_i == 32'd0);
  assign sdiv_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Swapping the divisor for 1 keeps the dividers well defined: for
  // 0x80000000 / -1 dividing by 1 yields exactly the architected answer
  // (quotient 0x80000000, remainder 0), and the b == 0 result is discarded.
  assign divisor_s = (b_zero || sdiv_ovf) ? 32'd1 : b_i;
  assign divisor_u = b_zero ? 32'd1 : b_i;

  assign quo_s = $signed(a_i) / $signed(divisor_s);
  assign rem_s = $signed(a_i) % $signed(divisor_s);
  assign quo_u = a_i / divisor_u;
  assign rem_u = a_i % divisor_u;

  assign div_by_zero_o = b_zero && is_div_op(op_i);

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_i, lo_i};
`else
  logic unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  always_comb begin
    result_o = 64'd0;
    case (op_i)
      OP_MULT:  result_o = prod_s;
      OP_MULTU: result_o = prod_u;
      OP_DIV:   result_o = {rem_s, quo_s};
      OP_DIVU:  result_o = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result_o = acc + prod_s;
      OP_MADDU: result_o = acc + prod_u;
      OP_MSUB:  result_o = acc - prod_s;
      OP_MSUBU: result_o = acc - prod_u;
`endif
      default:  result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Execute-stage multiply/divide unit. Owns the HI/LO registers, models the
// multi-cycle mult/div latency with a countdown and reports Start/Busy to the
// hazard unit.
//   clk    : clock, all state updates on the rising edge
//   reset  : asynchronous, active-low; clears hi/lo/pending/countdown
//   md     : mdu_if.slave (HILOOp, A, B in; Start, Busy, HILOOut out)
// Parameters:
//   MULT_CYCLES : busy cycles for mult/multu/madd family (1..15)
//   DIV_CYCLES  : busy cycles for div/divu (1..15)
// Optional feature: define MDU_MADD_EN to enable opcodes 9-12.
// -----------------------------------------------------------------------------
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  md
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hilo_op_e         op;
  logic             busy;
  logic             start;
  logic [63:0]      arith_res;
  logic             arith_dz;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op    = hilo_op_e'(md.HILOOp);
  assign busy  = (cnt_q != '0);
  // Ops presented while busy are never accepted; the hazard unit keeps them out.
  assign start = is_md_op(op) && !busy;

  mdu_arith u_arith (
    .op_i          (op),
    .a_i           (md.A),
    .b_i           (md.B),
    .hi_i          (hi_q),
    .lo_i          (lo_q),
    .result_o      (arith_res),
    .div_by_zero_o (arith_dz)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;

    if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start) begin
      // hi/lo cannot change while busy, so latching the current value as the
      // pending result makes a divide by zero commit "unchanged".
      {pend_hi_d, pend_lo_d} = arith_dz ? {hi_q, lo_q} : arith_res;
      cnt_d = is_div_op(op) ? DIV_LAT : MULT_LAT;
    end else begin
      if (op == OP_MTHI) hi_d = md.A;
      if (op == OP_MTLO) lo_d = md.A;
    end
  end

  // NOTE: every state register, including the pending result, is cleared by
  // reset so an aborted operation can never commit afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values sampled before the edge.
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign md.Start   = start;
  assign md.Busy    = busy;
  assign md.HILOOut = (op == OP_MFHI) ? hi_q :
                      (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. A behavioural model (cycle-indexed
// pending result and commit cycle, results from 64-bit integer arithmetic)
// predicts Start, Busy and HILOOut for every cycle; directed cases pin the
// model with literal values, then randomized traffic exercises the rest.
// Build with MDU_MADD_EN defined to include the madd family.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mdu_if md ();

  mult_div_unit #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (md)
  );

  always #5 clk = ~clk;

  // Start must never be raised for an op presented while busy.
  always @(posedge clk)
    if (rst_n) assert (!(md.Start && md.Busy))
      else $error("FAIL start_while_busy: Start and Busy both high");

  int vectors     = 0;
  int miscompares = 0;

  // Model state: committed hi/lo, pending result, last busy cycle index.
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  int          busy_last;
  int          cyc;

  // Samples of the last step, for literal checks.
  logic        s_busy;
  logic [31:0] s_out, s_exp_out;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_is_md(int op);
`ifdef MDU_MADD_EN
    return (op >= 1 && op <= 4) || (op >= 9 && op <= 12);
`else
    return (op >= 1 && op <= 4);
`endif
  endfunction

  function automatic logic [63:0] model_calc(int op, logic [31:0] a,
                                             logic [31:0] b, logic [63:0] acc);
    int                sa32, sb32;
    longint            sa, sb, q, r;
    longint unsigned   ua, ub, uq, ur;
    logic [63:0]       res;
    sa32 = a;  sb32 = b;
    sa   = sa32; sb = sb32;
    ua   = {32'd0, a}; ub = {32'd0, b};
    res  = acc;
    case (op)
      1: res = sa * sb;
      2: res = ua * ub;
      3: if (b != 0) begin
           q = sa / sb; r = sa - q * sb;  // 64-bit math: no INT_MIN/-1 trap
           res = {r[31:0], q[31:0]};
         end
      4: if (b != 0) begin
           uq = ua / ub; ur = ua - uq * ub;
           res = {ur[31:0], uq[31:0]};
         end
      9:  res = acc + sa * sb;
      10: res = acc + ua * ub;
      11: res = acc - sa * sb;
      12: res = acc - ua * ub;
      default: res = acc;
    endcase
    return res;
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_pend_hi = '0; m_pend_lo = '0;
    busy_last = -1;
  endtask

  // One clock cycle: drive op, compare at the falling edge, advance the model.
  task automatic step(int op, logic [31:0] a, logic [31:0] b);
    bit          exp_busy, exp_start;
    logic [31:0] exp_out;
    md.HILOOp = 4'(op); md.A = a; md.B = b;
    @(negedge clk);
    exp_busy  = (cyc <= busy_last);
    exp_start = model_is_md(op) && !exp_busy;
    exp_out   = (op == 5) ? m_hi : (op == 6) ? m_lo : 32'd0;
    s_busy    = md.Busy;
    s_out     = md.HILOOut;
    s_exp_out = exp_out;
    check("start",    {31'd0, md.Start}, {31'd0, exp_start});
    check("busy",     {31'd0, md.Busy},  {31'd0, exp_busy});
    check("hilo_out", md.HILOOut,        exp_out);
    @(posedge clk);
    if (cyc == busy_last) begin
      m_hi = m_pend_hi; m_lo = m_pend_lo;
    end
    if (exp_start) begin
      {m_pend_hi, m_pend_lo} = model_calc(op, a, b, {m_hi, m_lo});
      busy_last = cyc + ((op == 3 || op == 4) ? DL : ML);
    end else if (!exp_busy && op == 7) m_hi = a;
    else if (!exp_busy && op == 8) m_lo = a;
    cyc++;
    #1;
  endtask

  task automatic read_expect(int op, logic [31:0] lit, string name);
    step(op, 32'd0, 32'd0);
    check({name, "_dut"},   s_out,     lit);
    check({name, "_model"}, s_exp_out, lit);
  endtask

  // Count busy cycles after an accept while reading hi/lo (bounded).
  task automatic busy_len(int rd_op, int exp_len, string name);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      step(rd_op, 32'd0, 32'd0);
      if (s_busy) n++;
      else break;
    end
    check(name, 32'(n), 32'(exp_len));
  endtask

  initial begin
    int          op, sel;
    logic [31:0] a, b;
    int          busy_ops[$];

    md.HILOOp = '0; md.A = '0; md.B = '0;
    cyc = 0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    md.HILOOp = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, md.Busy}, 32'd0);
    check("reset_hi",   md.HILOOut,       32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned multiply latency: 0xFFFFFFFF * 2
    step(2, 32'hFFFF_FFFF, 32'd2);
    busy_len(5, ML, "multu_busy_len");
    check("multu_hi_first", s_out, 32'h0000_0001);
    read_expect(5, 32'h0000_0001, "multu_hi");
    read_expect(6, 32'hFFFF_FFFE, "multu_lo");

    // Signed divide: -7 / 2
    step(3, 32'hFFFF_FFF9, 32'd2);
    busy_len(6, DL, "div_busy_len");
    read_expect(6, 32'hFFFF_FFFD, "div_lo");
    read_expect(5, 32'hFFFF_FFFF, "div_hi");

    // Divide by zero leaves hi/lo untouched
    step(7, 32'h11, 32'd0);
    step(8, 32'h22, 32'd0);
    step(4, 32'h1234, 32'd0);
    busy_len(5, DL, "dz_busy_len");
    read_expect(5, 32'h11, "dz_hi");
    read_expect(6, 32'h22, "dz_lo");

    // Signed overflow divide
    step(3, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(6, DL, "ovf_busy_len");
    read_expect(6, 32'h8000_0000, "ovf_lo");
    read_expect(5, 32'h0000_0000, "ovf_hi");

    // Reserved / disabled opcodes act as none
    for (int k = 9; k <= 15; k++) begin
`ifdef MDU_MADD_EN
      if (k <= 12) continue;
`endif
      step(k, 32'd3, 32'd4);
    end

`ifdef MDU_MADD_EN
    // madd: {0,5} + 3*4
    step(7, 32'd0, 32'd0);
    step(8, 32'd5, 32'd0);
    step(9, 32'd3, 32'd4);
    busy_len(6, ML, "madd_busy_len");
    read_expect(6, 32'd17, "madd_lo");
    read_expect(5, 32'd0,  "madd_hi");
`endif

    // Randomized traffic; md/mt ops only when the model says the unit is idle.
    busy_ops = '{0, 5, 6, 13, 14, 15};
`ifndef MDU_MADD_EN
    busy_ops.push_back(9);  busy_ops.push_back(10);
    busy_ops.push_back(11); busy_ops.push_back(12);
`endif
    for (int i = 0; i < 600; i++) begin
      if (cyc <= busy_last)
        op = busy_ops[$urandom_range(0, busy_ops.size() - 1)];
      else
        op = $urandom_range(0, 15);
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 15)) - 32'd8;
                 b = 32'($urandom_range(0, 15)) - 32'd8; end
        default: ;
      endcase
      step(op, a, b);
    end

    // Reset mid-operation: Busy drops at once, nothing commits later.
    while (cyc <= busy_last) step(0, 32'd0, 32'd0);
    step(7, 32'hAAAA, 32'd0);
    step(1, 32'd7, 32'd9);
    step(0, 32'd0, 32'd0);
    step(0, 32'd0, 32'd0);
    md.HILOOp = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, md.Busy}, 32'd0);
    check("rst_mid_hi",   md.HILOOut,       32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) step((i % 2) ? 6 : 5, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
